// File: rtl/tessia_alu_pkg.sv
// Shared opcode, flag-index and width definitions for the Tessia ALU responder.
package tessia_alu_pkg;

  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned FLAGS_W = 4;

  typedef enum logic [CTRL_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRA = 4'd6,
    OP_MUL = 4'd7
  } alu_op_e;

  localparam int unsigned FLAG_NEG   = 3;
  localparam int unsigned FLAG_ZERO  = 2;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_OVF   = 0;

  localparam logic [FLAGS_W-1:0] ILLEGAL_FLAGS = 4'b0100;

endpackage

// File: rtl/alu_compute.sv
// Combinational ALU datapath between the operand stage and the response stage.
module alu_compute
  import tessia_alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  input  logic [CTRL_W-1:0]  ctrl,
  output logic [N-1:0]       result,
  output logic [FLAGS_W-1:0] flags,
  output logic               illegal
);

  localparam int unsigned SH_W = $clog2(N);

  logic [N:0]      sum;
  logic [N:0]      diff;
  logic [2*N-1:0]  prod;
  logic [SH_W-1:0] sh;
  logic            carry;
  logic            ovf;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  // Sign-extended operands make the low 2N bits equal the signed product.
  assign prod = {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b};
  assign sh   = b[SH_W-1:0];

  always_comb begin
    result  = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    flags   = '0;
    case (ctrl)
      OP_ADD: begin
        result = sum[N-1:0];
        carry  = sum[N];
        ovf    = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        result = diff[N-1:0];
        carry  = !diff[N];
        ovf    = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLL: result = a << sh;
      OP_SRA: result = N'($signed(a) >>> sh);
      OP_MUL: begin
        result = prod[N-1:0];
        ovf    = (prod[2*N-1:N-1] != {(N+1){prod[N-1]}});
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      flags = ILLEGAL_FLAGS;
    end else begin
      flags[FLAG_NEG]   = result[N-1];
      flags[FLAG_ZERO]  = (result == '0);
      flags[FLAG_CARRY] = carry;
      flags[FLAG_OVF]   = ovf;
    end
  end

endmodule

// File: rtl/alu_issue_responder.sv
// Two-stage valid/ready ALU responder: operand stage, compute, registered response stage.
module alu_issue_responder
  import tessia_alu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [N-1:0]       req_a,
  input  logic [N-1:0]       req_b,
  input  logic [CTRL_W-1:0]  req_ctrl,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N-1:0]       rsp_result,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic               rsp_illegal,
  output logic [CNT_W-1:0]   op_count
);

  logic              s1_valid;
  logic [N-1:0]      s1_a;
  logic [N-1:0]      s1_b;
  logic [CTRL_W-1:0] s1_ctrl;

  logic [N-1:0]       alu_result;
  logic [FLAGS_W-1:0] alu_flags;
  logic               alu_illegal;

  logic s2_load_c;
  logic s1_adv_c;
  logic accept_c;

  // Stage 2 frees up when empty or draining; stage 1 frees up when it can move on.
  assign s2_load_c = !rsp_valid || rsp_ready;
  assign s1_adv_c  = s1_valid && s2_load_c;
  assign req_ready = rst_n && (!s1_valid || s1_adv_c);
  assign accept_c  = req_valid && req_ready;

  alu_compute #(.N(N)) u_compute (
    .a       (s1_a),
    .b       (s1_b),
    .ctrl    (s1_ctrl),
    .result  (alu_result),
    .flags   (alu_flags),
    .illegal (alu_illegal)
  );

  // Operand stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_ctrl  <= '0;
    end else if (accept_c) begin
      s1_valid <= 1'b1;
      s1_a     <= req_a;
      s1_b     <= req_b;
      s1_ctrl  <= req_ctrl;
    end else if (s1_adv_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Response stage; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_illegal <= 1'b0;
    end else if (s2_load_c) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_result  <= alu_result;
        rsp_flags   <= alu_flags;
        rsp_illegal <= alu_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (accept_c) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_responder.sv
// Scoreboard bench for alu_issue_responder: driver pushes expected responses, monitor pops and compares.
module tb_alu_issue_responder;
  import tessia_alu_pkg::*;

  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = 4;
  localparam int          MAXS  = (2 ** (N - 1)) - 1;
  localparam int          MINS  = -(2 ** (N - 1));

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [N-1:0]     req_a;
  logic [N-1:0]     req_b;
  logic [3:0]       req_ctrl;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_illegal;
  logic [CNT_W-1:0] op_count;

  alu_issue_responder #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ctrl    (req_ctrl),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_illegal (rsp_illegal),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] result;
    logic [3:0]   flags;
    logic         illegal;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t dir_exp;
  int   errors;
  int   checks;
  int   cyc;
  int   n_acc;
  bit   chk_lat;
  bit   head_seen;
  bit   use_dir;
  bit   last_acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model from the arithmetic rules, using plain integer ranges.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] ctrl);
    exp_t e;
    int   sa, sb, ua, ub, k, r;
    bit   c, o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    k  = ub % N;
    r = 0; c = 0; o = 0;
    e.illegal = 1'b0;
    e.cyc     = 0;
    case (ctrl)
      4'd0: begin r = sa + sb; c = (ua + ub) >= (2 ** N); o = (r > MAXS) || (r < MINS); end
      4'd1: begin r = sa - sb; c = (ua >= ub); o = (r > MAXS) || (r < MINS); end
      4'd2: r = int'(a & b);
      4'd3: r = int'(a | b);
      4'd4: r = int'(a ^ b);
      4'd5: r = ua * (2 ** k);
      4'd6: r = sa >>> k;
      4'd7: begin r = sa * sb; o = (r > MAXS) || (r < MINS); end
      default: e.illegal = 1'b1;
    endcase
    e.result = e.illegal ? '0 : N'(r);
    e.flags  = e.illegal ? 4'b0100 : {e.result[N-1], e.result == '0, c, o};
    return e;
  endfunction

  // One clock: record an accept at the falling edge, then advance past the rising edge.
  task automatic step();
    exp_t e;
    last_acc = 1'b0;
    @(negedge clk);
    if (rst_n && req_valid && req_ready) begin
      e       = use_dir ? dir_exp : model(req_a, req_b, req_ctrl);
      e.cyc   = cyc;
      q.push_back(e);
      n_acc++;
      last_acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] ctrl,
                       input bit dir, input logic [N-1:0] dres, input logic [3:0] dfl, input logic dill);
    bit got;
    req_a = a; req_b = b; req_ctrl = ctrl; req_valid = 1'b1;
    use_dir = dir;
    dir_exp.result = dres; dir_exp.flags = dfl; dir_exp.illegal = dill; dir_exp.cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = last_acc;
    end
    if (!got) check(1'b0, "issue_timeout", 32'(0), 32'(1));
    use_dir = 1'b0;
  endtask

  task automatic issue_rand();
    issue(N'($urandom), N'($urandom), 4'($urandom_range(0, 9)), 1'b0, '0, '0, 1'b0);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    check(q.size() == 0, "drain", 32'(q.size()), 32'(0));
  endtask

  // Monitor: pops and compares on every response transfer; checks hold during stalls.
  initial begin
    exp_t         e;
    logic [N-1:0] pr;
    logic [3:0]   pf;
    logic         pi;
    bit           pstall;
    pstall = 1'b0; pr = '0; pf = '0; pi = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pstall    = 1'b0;
        head_seen = 1'b0;
      end else begin
        if (pstall)
          check(rsp_valid === 1'b1 && rsp_result === pr && rsp_flags === pf && rsp_illegal === pi,
                "stall_hold", 32'({rsp_valid, rsp_result, rsp_flags, rsp_illegal}),
                32'({1'b1, pr, pf, pi}));
        if (rsp_valid === 1'b1) begin
          if (q.size() == 0) begin
            check(1'b0, "unexpected_rsp", 32'(rsp_result), 32'(0));
          end else begin
            if (!head_seen) begin
              head_seen = 1'b1;
              if (chk_lat) check((cyc - q[0].cyc) == 2, "latency", 32'(cyc - q[0].cyc), 32'(2));
            end
            if (rsp_ready === 1'b1) begin
              e = q.pop_front();
              check(rsp_result === e.result && rsp_flags === e.flags && rsp_illegal === e.illegal,
                    "rsp_data", 32'({rsp_result, rsp_flags, rsp_illegal}),
                    32'({e.result, e.flags, e.illegal}));
              head_seen = 1'b0;
            end
          end
        end
        pstall = (rsp_valid === 1'b1) && (rsp_ready === 1'b0);
        pr = rsp_result; pf = rsp_flags; pi = rsp_illegal;
      end
    end
  end

  initial begin
    int c0, acc0;
    errors = 0; checks = 0; cyc = 0; n_acc = 0;
    chk_lat = 1'b0; head_seen = 1'b0; use_dir = 1'b0; last_acc = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_ctrl = '0;

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      check(req_ready === 1'b0, "ready_in_reset", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check(rsp_valid === 1'b0, "idle_rsp_valid", 32'(rsp_valid), 32'(0));
    check(op_count === '0, "idle_op_count", 32'(op_count), 32'(0));
    check(req_ready === 1'b1, "idle_req_ready", 32'(req_ready), 32'(1));
    @(posedge clk);
    #1;

    // Directed flag cases with fixed expectations
    chk_lat = 1'b1;
    issue(8'h7F, 8'h01, 4'd0, 1'b1, 8'h80, 4'b1001, 1'b0);
    issue(8'h05, 8'h05, 4'd1, 1'b1, 8'h00, 4'b0110, 1'b0);
    issue(8'hFF, 8'h01, 4'd0, 1'b1, 8'h00, 4'b0110, 1'b0);
    issue(8'h5A, 8'h33, 4'hC, 1'b1, 8'h00, 4'b0100, 1'b1);
    drain();

    // Back-to-back stream over every legal opcode
    c0 = cyc; acc0 = n_acc;
    for (int op = 0; op < 8; op++) issue(N'($urandom), N'($urandom), 4'(op), 1'b0, '0, '0, 1'b0);
    req_valid = 1'b0;
    check((cyc - c0) == 8, "stream_no_bubble", 32'(cyc - c0), 32'(8));
    check((n_acc - acc0) == 8, "stream_count", 32'(n_acc - acc0), 32'(8));
    drain();
    check(op_count === CNT_W'(n_acc), "op_count_stream", 32'(op_count), 32'(CNT_W'(n_acc)));

    // Back-pressure: two in flight, third held off until the first drain
    chk_lat = 1'b0;
    rsp_ready = 1'b0;
    acc0 = n_acc;
    req_valid = 1'b1;
    req_a = N'($urandom); req_b = N'($urandom); req_ctrl = 4'd7;
    step();
    req_a = N'($urandom); req_b = N'($urandom); req_ctrl = 4'd1;
    step();
    req_a = N'($urandom); req_b = N'($urandom); req_ctrl = 4'd6;
    repeat (4) step();
    check((n_acc - acc0) == 2, "bp_accepts", 32'(n_acc - acc0), 32'(2));
    check(req_ready === 1'b0, "bp_ready_low", 32'(req_ready), 32'(0));
    rsp_ready = 1'b1;
    #1;
    check(req_ready === 1'b1 && rsp_valid === 1'b1, "bp_release", 32'({req_ready, rsp_valid}), 32'(2'b11));
    step();
    check((n_acc - acc0) == 3, "bp_third_accept", 32'(n_acc - acc0), 32'(3));
    drain();

    // Randomized traffic with random back-pressure and illegal opcodes
    req_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!req_valid || last_acc) begin
        req_valid = ($urandom_range(0, 9) < 7);
        req_a = N'($urandom); req_b = N'($urandom); req_ctrl = 4'($urandom_range(0, 9));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    drain();
    check(op_count === CNT_W'(n_acc), "op_count_random", 32'(op_count), 32'(CNT_W'(n_acc)));

    // Reset with two operations stalled in flight
    rsp_ready = 1'b0;
    issue_rand();
    issue_rand();
    req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    q.delete();
    n_acc = 0;
    check(rsp_valid === 1'b0, "rst_mid_valid", 32'(rsp_valid), 32'(0));
    check(op_count === '0, "rst_mid_count", 32'(op_count), 32'(0));
    rsp_ready = 1'b1;
    repeat (6) step();

    // Counter wrap: 17 accepts on a 4-bit counter
    chk_lat = 1'b1;
    repeat (17) issue_rand();
    req_valid = 1'b0;
    check(op_count === CNT_W'(1), "op_count_wrap", 32'(op_count), 32'(1));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
